// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
// Build option UART_TX_PARITY_EN adds an even-parity bit to each frame.
package fifo_uart_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  // Counter width for a modulus of n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int BAUD_CNT_W_DEF = cnt_width(CLKS_PER_BIT_DEF);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module uart_baud_counter
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int                CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO byte by byte onto an 8N1 UART line.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_re,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int               IDX_W    = cnt_width(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  tx_q, tx_d;
  logic                  tick;
  logic                  baud_clr;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  // Gated by reset so a held reset can never pop (and lose) a byte.
  assign fifo_re  = rst && (state_q == IDLE) && tx_en && !fifo_empty;
  assign busy     = (state_q != IDLE) || fifo_re;
  assign tx_done  = (state_q == STOP) && tick;
  assign tx       = tx_q;
  assign baud_clr = (state_d != state_q) || (state_q == IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (baud_clr),
    .tick(tick)
  );

  // NOTE: every variable gets a default before the case so no path
  // leaves one unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (fifo_re) state_d = LOAD;
      end
      LOAD: begin
        shreg_d = fifo_r_data;
`ifdef UART_TX_PARITY_EN
        parity_d = ^fifo_r_data;
`endif
        tx_d    = 1'b0;
        state_d = START;
      end
      START: begin
        if (tick) begin
          tx_d    = shreg_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            shreg_d   = shreg_q >> 1;
            tx_d      = shreg_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule
